// File: rtl/seq_mult_pkg.sv
// Shared state encoding and configuration helpers for the seq_mult_hs multiplier.
// Every helper is a constant function, so it can size localparams in the modules that import it.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic bit bpc_valid(input int width, input int bpc);
    return (width >= 2) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

  function automatic int num_digits(input int width, input int bpc);
    return width / bpc;
  endfunction

  // One extra bit so the counter can hold the digit count itself without wrapping.
  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_pp.sv
// Combinational partial product of the multiplicand and one multiplier digit.
module seq_mult_pp #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]                i_mcand,
  input  logic [BITS_PER_CYCLE-1:0]       i_digit,
  output logic [WIDTH+BITS_PER_CYCLE-1:0] o_pp
);

  localparam int PP_W = WIDTH + BITS_PER_CYCLE;

  assign o_pp = PP_W'(i_mcand) * PP_W'(i_digit);

endmodule

// File: rtl/seq_mult_hs.sv
// Shift-and-add multiplier with valid/ready handshakes, retiring BITS_PER_CYCLE multiplier
// bits per clock on operand magnitudes; the sign is applied once, after accumulation.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_EXIT     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N     = num_digits(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam int ACC_W = 2 * WIDTH;
  localparam int PP_W  = WIDTH + BITS_PER_CYCLE;

  if (!bpc_valid(WIDTH, BITS_PER_CYCLE)) begin : g_cfg_check
    $error("seq_mult_hs: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    return (is_signed && v[WIDTH-1]) ? neg_v : v;
  endfunction

  function automatic logic [ACC_W-1:0] apply_sign(input logic [ACC_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic                r_neg;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_product;

  logic [PP_W-1:0]     w_pp;
  logic [WIDTH-1:0]    w_mplier_shr;
  logic [31:0]         w_shamt;
  logic [ACC_W-1:0]    w_pp_aligned;
  logic                w_last;
  logic                w_exit;
  logic                w_accept;

  seq_mult_pp #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_pp (
    .i_mcand (r_mcand),
    .i_digit (r_mplier[BITS_PER_CYCLE-1:0]),
    .o_pp    (w_pp)
  );

  assign w_mplier_shr = r_mplier >> BITS_PER_CYCLE;
  assign w_shamt      = 32'(r_cnt) * 32'(BITS_PER_CYCLE);
  assign w_pp_aligned = ACC_W'(w_pp) << w_shamt;
  assign w_last       = (r_cnt == CNT_W'(N - 1));
  assign w_exit       = w_last || ((EARLY_EXIT != 0) && (w_mplier_shr == '0));
  assign w_accept     = (r_state == IDLE) && in_valid && !abort;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == CALC) || (r_state == SIGN);
  assign product   = r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // abort outranks every other transition once an operation is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC;
      CALC:    if (abort) w_state_nxt = IDLE;
               else if (w_exit) w_state_nxt = SIGN;
      SIGN:    w_state_nxt = abort ? IDLE : DONE;
      DONE:    if (abort || out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= magnitude($signed(a), signed_mode);
            r_mplier <= magnitude($signed(b), signed_mode);
            r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt    <= '0;
            r_acc    <= '0;
          end
        end
        CALC: begin
          if (abort) begin
            r_product <= '0;
          end else begin
            r_acc    <= r_acc + w_pp_aligned;
            r_mplier <= w_mplier_shr;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        SIGN: begin
          if (abort) r_product <= '0;
          else       r_product <= apply_sign(r_acc, r_neg);
        end
        DONE: begin
          if (abort) r_product <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Drives three seq_mult_hs configurations (1 bit/cycle, 2 bits/cycle, early exit) in lockstep
// and checks them against an arithmetic reference model of product and latency.
module tb_seq_mult_hs;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              signed_mode = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b1;
  logic [7:0]        a = 8'd0;
  logic [7:0]        b = 8'd0;
  logic [2:0]        in_ready;
  logic [2:0]        out_valid;
  logic [2:0]        busy;
  logic [2:0][15:0]  product;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_mult_hs #(.WIDTH(8), .BITS_PER_CYCLE(1), .EARLY_EXIT(0)) u_bpc1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a), .b(b),
    .signed_mode(signed_mode), .abort(abort), .out_valid(out_valid[0]), .out_ready(out_ready),
    .product(product[0]), .busy(busy[0]));

  seq_mult_hs #(.WIDTH(8), .BITS_PER_CYCLE(2), .EARLY_EXIT(0)) u_bpc2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a), .b(b),
    .signed_mode(signed_mode), .abort(abort), .out_valid(out_valid[1]), .out_ready(out_ready),
    .product(product[1]), .busy(busy[1]));

  seq_mult_hs #(.WIDTH(8), .BITS_PER_CYCLE(1), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .a(a), .b(b),
    .signed_mode(signed_mode), .abort(abort), .out_valid(out_valid[2]), .out_ready(out_ready),
    .product(product[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_prod(input logic [7:0] x, input logic [7:0] y, input bit sm);
    longint px, py;
    px = sm ? longint'($signed(x)) : longint'(x);
    py = sm ? longint'($signed(y)) : longint'(y);
    return 16'(px * py);
  endfunction

  // Edges from accept to out_valid: digits + 1, or significant bits of |y| + 1 with early exit.
  function automatic int model_lat(input int d, input logic [7:0] y, input bit sm);
    int mag, k;
    if (d == 0) return 9;
    if (d == 1) return 5;
    mag = (sm && y[7]) ? 256 - int'(y) : int'(y);
    k = 1;
    while ((mag >> k) != 0) k++;
    return k + 1;
  endfunction

  task automatic check_idle(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s u%0d in_ready", tag, d), in_ready[d], 1'b1);
      check($sformatf("%s u%0d out_valid", tag, d), out_valid[d], 1'b0);
      check($sformatf("%s u%0d busy", tag, d), busy[d], 1'b0);
    end
  endtask

  // Called #1 after the accept edge; out_ready must be high.
  task automatic collect(input logic [7:0] x, input logic [7:0] y, input bit sm);
    logic [2:0] done;
    int e;
    done = '0;
    e = 0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("u%0d busy after accept", d), busy[d], 1'b1);
      check($sformatf("u%0d in_ready after accept", d), in_ready[d], 1'b0);
    end
    while (done != 3'b111 && e <= 30) begin
      for (int d = 0; d < 3; d++) begin
        if (!done[d] && out_valid[d]) begin
          check($sformatf("u%0d latency a=%0h b=%0h s=%0d", d, x, y, sm), e, model_lat(d, y, sm));
          check($sformatf("u%0d product a=%0h b=%0h s=%0d", d, x, y, sm), product[d],
                model_prod(x, y, sm));
          check($sformatf("u%0d busy in done", d), busy[d], 1'b0);
          check($sformatf("u%0d in_ready in done", d), in_ready[d], 1'b0);
          done[d] = 1'b1;
        end
      end
      if (done != 3'b111) begin
        step();
        e++;
      end
    end
    for (int d = 0; d < 3; d++)
      check($sformatf("u%0d completed", d), done[d], 1'b1);
    step();
    check_idle("after handshake");
  endtask

  task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input bit sm);
    for (int d = 0; d < 3; d++)
      check($sformatf("u%0d ready before accept", d), in_ready[d], 1'b1);
    a = x;
    b = y;
    signed_mode = sm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    signed_mode = 1'($urandom);
    collect(x, y, sm);
  endtask

  initial begin
    logic [7:0] x, y;
    bit sm;
    logic [2:0] rose;
    int guard;

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    for (int d = 0; d < 3; d++)
      check($sformatf("reset u%0d product", d), product[d], 16'h0);
    rst_n = 1'b1;
    step();

    run_txn(8'd200, 8'd150, 1'b0);
    run_txn(8'h80, 8'h80, 1'b1);
    run_txn(8'hF9, 8'd9, 1'b1);
    run_txn(8'd255, 8'd3, 1'b0);
    run_txn(8'd255, 8'd0, 1'b0);
    run_txn(8'd0, 8'h85, 1'b1);
    run_txn(8'h80, 8'h7F, 1'b1);
    run_txn(8'hFF, 8'hFF, 1'b0);
    run_txn(8'h7F, 8'h80, 1'b1);

    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      sm = 1'($urandom);
      if (i % 5 == 0) y = y & 8'h07;
      run_txn(x, y, sm);
    end

    run_txn(8'd12, 8'd13, 1'b0);

    // abort while idle blocks acceptance
    a = 8'd3;
    b = 8'd4;
    in_valid = 1'b1;
    abort = 1'b1;
    step();
    in_valid = 1'b0;
    abort = 1'b0;
    check_idle("abort in idle");

    // abort during the third CALC cycle
    a = 8'd17;
    b = 8'd19;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    for (int d = 0; d < 3; d++)
      check($sformatf("u%0d busy before abort", d), busy[d], 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("after abort");
    for (int d = 0; d < 3; d++)
      check($sformatf("u%0d product after abort", d), product[d], 16'h0);
    rose = '0;
    repeat (12) begin
      step();
      rose |= out_valid;
    end
    check("out_valid after abort", rose, 3'b000);
    run_txn(8'd5, 8'd6, 1'b0);

    // back-pressure: result held while out_ready is low, no accept until after handshake
    out_ready = 1'b0;
    a = 8'h37;
    b = 8'hA5;
    signed_mode = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    guard = 0;
    while (out_valid != 3'b111 && guard < 30) begin
      step();
      guard++;
    end
    check("all valid under back-pressure", out_valid, 3'b111);
    a = 8'h5A;
    b = 8'hC3;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    repeat (10) begin
      step();
      for (int d = 0; d < 3; d++) begin
        check($sformatf("u%0d held valid", d), out_valid[d], 1'b1);
        check($sformatf("u%0d held product", d), product[d], model_prod(8'h37, 8'hA5, 1'b1));
        check($sformatf("u%0d no accept in done", d), in_ready[d], 1'b0);
      end
    end
    out_ready = 1'b1;
    step();
    check_idle("handshake edge");
    step();
    in_valid = 1'b0;
    collect(8'h5A, 8'hC3, 1'b0);

    // asynchronous reset in the middle of CALC
    run_txn(8'd100, 8'd3, 1'b0);
    a = 8'd200;
    b = 8'd150;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async reset");
    for (int d = 0; d < 3; d++)
      check($sformatf("async reset u%0d product", d), product[d], 16'h0);
    step();
    rst_n = 1'b1;
    step();
    run_txn(8'd200, 8'd150, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
Parametrised shift-and-add multiplier with valid/ready handshakes on input and output. It retires BITS_PER_CYCLE multiplier bits per clock. It supports unsigned or two's-complement signed operands per transaction, optional early exit when the remaining multiplier bits are zero, and a synchronous abort. It is the area-efficient multiplier for datapaths that need throttled, back-pressured operation.

Parameters:
WIDTH, 8, operand width; must be >= 2.
BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle; must divide WIDTH (1, 2, 4 ...).
EARLY_EXIT, 0, 1 = leave CALC as soon as the remaining multiplier magnitude is 0.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands and mode are valid.
in_ready  out  1  block can accept operands.
a  in  WIDTH  multiplicand.
b  in  WIDTH  multiplier.
signed_mode  in  1  1 = a and b are two's complement; sampled with the operands.
abort  in  1  cancel the current operation.
out_valid  out  1  product is valid.
out_ready  in  1  consumer accepts the product.
product  out  2*WIDTH  result; signed or unsigned per the sampled mode.
busy  out  1  high in CALC or SIGN.

Behaviour:
- Reset: state IDLE, out_valid=0, product=0, busy=0, in_ready=1, all internal registers 0.
- States are IDLE, CALC, SIGN and DONE. N = WIDTH/BITS_PER_CYCLE.
- IDLE:
  - in_ready=1.
  - Accept on an edge with in_valid=1: latch |a| and |b| (magnitudes when signed_mode=1, else raw values), latch neg = signed_mode & (a[MSB]^b[MSB]), clear the accumulator, clear the digit counter, go to CALC.
- CALC, each edge:
  - digit = mplier[BITS_PER_CYCLE-1:0].
  - acc += (mcand*digit) << (counter*BITS_PER_CYCLE).
  - mplier >>= BITS_PER_CYCLE; counter++.
  - Go to SIGN after the N-th CALC edge. With EARLY_EXIT=1, also go to SIGN on any edge where the post-shift mplier is 0.
- SIGN, one edge: product <= neg ? -acc : acc (2*WIDTH bits, modulo 2^(2*WIDTH)); go to DONE.
- DONE:
  - out_valid=1, product held stable.
  - Go to IDLE on an edge with out_ready=1; out_valid drops after that edge.
  - No new accept while in DONE.
- Latency: out_valid rises N+1 edges after the accept edge (EARLY_EXIT=0). With early exit it is k+1 edges, where k is the number of CALC edges taken (1 <= k <= N).
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits. The product never overflows 2*WIDTH bits in either mode.
- A zero operand in any mode gives product 0. neg may be 1 in that case, and -0 = 0.
- in_ready is combinational from state only; it does not depend on out_ready (no same-cycle turnaround).
- abort:
  - In CALC, SIGN or DONE: next edge goes to IDLE, out_valid=0, product cleared to 0, no output handshake.
  - abort has priority over every other transition.
  - In IDLE: abort suppresses acceptance that cycle.
- Asynchronous reset mid-operation: immediate return to reset values; the in-flight result is lost.
- Inputs a, b and signed_mode are don't-care outside an accept edge.
- The product register is written only in SIGN (and cleared on abort/reset). Intermediate accumulation is never visible on product.

Decomposition:
- Shared package seq_mult_pkg:
  - state encoding (IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3);
  - the N / counter-width localparam derivation (counter width = $clog2(N)+1);
  - the divisibility check as a constant function.
- One sub-module, seq_mult_pp: combinational mcand (WIDTH) × digit (BITS_PER_CYCLE) partial product, WIDTH+BITS_PER_CYCLE bits. It is instantiated once; the shift/accumulate stays in the top level.

Test Plan:
1. WIDTH=8, BPC=1, unsigned: a=200, b=150, out_ready=1 -> product=30000 (0x7530); out_valid rises exactly 9 edges after accept; in_ready=0 until the return to IDLE.
2. WIDTH=8, BPC=2, signed: a=-128 (0x80), b=-128 -> product=16384 (0x4000), latency 5. Then a=-7, b=9 -> product=0xFFC1 (-63).
3. Back-pressure: product ready with out_ready=0 for 10 cycles -> out_valid stays 1 and product stays stable; in_valid=1 with new operands is not accepted until one cycle after the out_ready handshake.
4. EARLY_EXIT=1, BPC=1, unsigned: a=255, b=3 -> product=765, out_valid 3 edges after accept. Then b=0 -> product=0, 2 edges after accept.
5. abort asserted on the 3rd CALC cycle of a=17, b=19 -> next edge IDLE, out_valid never rises, product=0. A following a=5, b=6 gives 30 with nominal latency.
6. rst_n pulsed low asynchronously mid-CALC -> outputs return to reset values without a clock edge; the first transaction after release behaves per scenario 1.
